// File: rtl/program_sequencer.sv
// program_sequencer: fetches 9-bit instructions from a synchronous ROM and feeds them to the
// bus processor one Run pulse at a time, waiting for Done before advancing the PC.
module program_sequencer #(
   parameter int ADDR_W  = 5,
   parameter int TIMEOUT = 8
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Halt_req,
   output logic [ADDR_W-1:0] Mem_addr,
   input  logic [8:0]        Mem_data,
   output logic [8:0]        Proc_DIN,
   output logic              Proc_Run,
   input  logic              Proc_Done,
   output logic              Busy,
   output logic              Halted,
   output logic              Err,
   output logic [ADDR_W-1:0] PC,
   output logic [7:0]        Instr_count
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] DECODE = 3'd2;
   localparam logic [2:0] ISSUE  = 3'd3;
   localparam logic [2:0] WAIT   = 3'd4;
   localparam logic [2:0] HALTED = 3'd5;
   localparam int TW = $clog2(TIMEOUT);

   logic [2:0]    state;
   logic [8:0]    instr_q, imm_q;
   logic [TW-1:0] timer;
   logic          halt_pend;
   logic [2:0]    op;
   logic          is_mvi;

   assign op     = Mem_data[8:6];
   assign is_mvi = instr_q[8:6] == 3'b001;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         PC          <= '0;
         Err         <= 1'b0;
         Instr_count <= '0;
         halt_pend   <= 1'b0;
         instr_q     <= '0;
         imm_q       <= '0;
         timer       <= '0;
      end else begin
         if (Halt_req && Busy) halt_pend <= 1'b1;
         case (state)
            IDLE, HALTED: if (Start) begin
               PC          <= '0;
               Err         <= 1'b0;
               Instr_count <= '0;
               halt_pend   <= 1'b0;
               state       <= FETCH;
            end
            FETCH: state <= DECODE;
            DECODE: begin
               instr_q <= Mem_data;
               // 1xx opcodes never reach the processor: 111 is a clean halt, the rest are faults
               if (op[2]) begin
                  state <= HALTED;
                  Err   <= ~&op;
               end else state <= ISSUE;
            end
            ISSUE: begin
               imm_q <= Mem_data;
               PC    <= PC + ADDR_W'(is_mvi ? 2 : 1);
               timer <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (Proc_Done) begin
                  Instr_count <= Instr_count + {7'd0, ~&Instr_count};
                  state       <= (halt_pend || Halt_req) ? HALTED : FETCH;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  Err   <= 1'b1;
                  state <= HALTED;
               end else timer <= timer + TW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      Busy     = state == FETCH || state == DECODE || state == ISSUE || state == WAIT;
      Halted   = state == HALTED;
      Proc_Run = state == ISSUE;
      Mem_addr = state == DECODE ? PC + ADDR_W'(1) : PC;
      Proc_DIN = state == ISSUE ? instr_q : state == WAIT ? (is_mvi ? imm_q : instr_q) : 9'd0;
   end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: random and directed stimulus against a cycle-level behavioural model
// of the sequencer, plus literal expectations for the documented scenarios.
module tb_program_sequencer;
   localparam int AW = 5;
   localparam int TO = 8;
   localparam int N  = 1 << AW;

   logic          Clock = 1'b0;
   logic          Reset, Start, Halt_req, Proc_Done;
   logic [AW-1:0] Mem_addr, PC;
   logic [8:0]    Mem_data, Proc_DIN;
   logic          Proc_Run, Busy, Halted, Err;
   logic [7:0]    Instr_count;
   logic [8:0]    rom [N];

   program_sequencer #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Halt_req(Halt_req),
      .Mem_addr(Mem_addr), .Mem_data(Mem_data), .Proc_DIN(Proc_DIN), .Proc_Run(Proc_Run),
      .Proc_Done(Proc_Done), .Busy(Busy), .Halted(Halted), .Err(Err), .PC(PC),
      .Instr_count(Instr_count));

   always #5 Clock = ~Clock;
   always @(posedge Clock) Mem_data <= rom[Mem_addr];

   // model: m_step counts cycles into the current instruction (0 fetch, 1 decode, 2 issue, 3+ wait)
   bit m_run, m_halt, m_err, m_pend;
   int m_step, m_pc, m_ipc, m_cnt, m_wait;
   int checks = 0, failures = 0, n_runs = 0, done_pct = 40;

   function automatic int op_of(int a);
      logic [8:0] w;
      w = rom[a % N];
      return int'(w[8:6]);
   endfunction

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_halt = 0; m_err = 0; m_pend = 0; m_step = 0; m_pc = 0; m_cnt = 0; m_ipc = 0;
   endtask

   task automatic model_next(bit st, bit hr, bit dn);
      if (!m_run) begin
         if (st) begin
            m_run = 1; m_halt = 0; m_step = 0; m_pc = 0; m_err = 0; m_cnt = 0; m_pend = 0;
         end
      end else begin
         if (hr) m_pend = 1;
         if (m_step == 0) m_step = 1;
         else if (m_step == 1) begin
            m_ipc = m_pc;
            if (op_of(m_pc) >= 4) begin
               m_run = 0; m_halt = 1; m_err = op_of(m_pc) != 7;
            end else m_step = 2;
         end else if (m_step == 2) begin
            m_pc = (m_pc + (op_of(m_ipc) == 1 ? 2 : 1)) % N;
            m_step = 3; m_wait = 0;
         end else if (dn) begin
            m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
            if (m_pend) begin m_run = 0; m_halt = 1; end
            else m_step = 0;
         end else begin
            m_wait++;
            if (m_wait == TO) begin m_err = 1; m_run = 0; m_halt = 1; end
         end
      end
   endtask

   task automatic check_all();
      int ea, ed, er;
      ea = m_pc; ed = 0; er = 0;
      if (m_run && m_step == 1) ea = (m_pc + 1) % N;
      if (m_run && m_step == 2) begin er = 1; ed = rom[m_pc]; end
      if (m_run && m_step >= 3) ed = op_of(m_ipc) == 1 ? rom[(m_ipc + 1) % N] : rom[m_ipc];
      chk("Mem_addr", Mem_addr, ea);
      chk("Proc_DIN", Proc_DIN, ed);
      chk("Proc_Run", Proc_Run, er);
      chk("Busy", Busy, m_run);
      chk("Halted", Halted, m_halt);
      chk("Err", Err, m_err);
      chk("PC", PC, m_pc);
      chk("Instr_count", Instr_count, m_cnt);
   endtask

   task automatic cyc(bit st, bit hr, bit dn);
      Start = st; Halt_req = hr; Proc_Done = dn;
      model_next(st, hr, dn);
      @(negedge Clock);
      if (Proc_Run) n_runs++;
      check_all();
   endtask

   // processor stand-in: Done with done_pct% odds while waiting, stray Done pulses elsewhere
   task automatic auto(int pstart, int phalt);
      bit dn;
      dn = (m_run && m_step >= 3) ? $urandom_range(99) < done_pct : $urandom_range(99) < 10;
      cyc($urandom_range(99) < pstart, $urandom_range(99) < phalt, dn);
   endtask

   task automatic until_halt(int bound);
      int i;
      i = 0;
      while (!Halted && i < bound) begin auto(0, 0); i++; end
      chk("halt_reached", Halted, 1);
   endtask

   task automatic load(input logic [8:0] w0, w1, w2, w3, w4);
      for (int a = 0; a < N; a++) rom[a] = 9'h000;
      rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3; rom[4] = w4;
   endtask

   initial begin
      int i;
      Reset = 1; Start = 0; Halt_req = 0; Proc_Done = 0;
      load(0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge Clock);
      chk("rst_Busy", Busy, 0);
      chk("rst_Halted", Halted, 0);
      chk("rst_PC", PC, 0);
      chk("rst_Run", Proc_Run, 0);
      Reset = 0;
      @(negedge Clock);
      check_all();

      // mvi R0,#5; halt
      load(9'h040, 9'h005, 9'h1C0, 0, 0);
      n_runs = 0;
      cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
      chk("t1_run_latency", Proc_Run, 1);
      chk("t1_issue_din", Proc_DIN, 'h040);
      cyc(0, 0, 0);
      chk("t1_imm_din", Proc_DIN, 'h005);
      until_halt(100);
      chk("t1_pc", PC, 2);
      chk("t1_count", Instr_count, 1);
      chk("t1_err", Err, 0);
      chk("t1_runs", n_runs, 1);

      // mvi R0,#5; mvi R1,#3; add R0,R1; halt
      load(9'h040, 9'h005, 9'h048, 9'h003, 9'h081);
      rom[5] = 9'h1C0;
      cyc(1, 0, 0);
      until_halt(200);
      chk("t2_count", Instr_count, 3);
      chk("t2_pc", PC, 5);

      // Done never arrives: one Run, then TO wait cycles, then the fault
      load(9'h081, 9'h1C0, 0, 0, 0);
      n_runs = 0;
      cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
      chk("t3_run", Proc_Run, 1);
      i = 0;
      while (!Halted && i < 50) begin cyc(0, 0, 0); i++; end
      chk("t3_cycles_after_run", i, TO + 1);
      chk("t3_err", Err, 1);
      chk("t3_runs", n_runs, 1);

      // Halt_req during the first instruction's wait
      load(9'h081, 9'h081, 9'h081, 9'h1C0, 0);
      cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
      cyc(0, 1, 0);
      until_halt(100);
      chk("t4_count", Instr_count, 1);
      chk("t4_pc", PC, 1);
      chk("t4_err", Err, 0);
      cyc(1, 0, 0);
      chk("t4_restart_pc", PC, 0);
      until_halt(200);
      chk("t4_count2", Instr_count, 3);
      chk("t4_pc2", PC, 3);

      // illegal opcode at address 0
      load(9'h100, 0, 0, 0, 0);
      n_runs = 0;
      cyc(1, 0, 0);
      until_halt(20);
      chk("t5_runs", n_runs, 0);
      chk("t5_err", Err, 1);
      chk("t5_count", Instr_count, 0);

      // asynchronous reset in the middle of a wait
      load(9'h081, 9'h1C0, 0, 0, 0);
      cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
      #2 Reset = 1;
      #1;
      chk("t6_busy", Busy, 0);
      chk("t6_pc", PC, 0);
      chk("t6_addr", Mem_addr, 0);
      chk("t6_din", Proc_DIN, 0);
      model_reset();
      @(negedge Clock);
      Reset = 0;
      check_all();
      cyc(1, 0, 0);
      until_halt(100);
      chk("t6_count", Instr_count, 1);
      chk("t6_pc_end", PC, 1);

      // random programs with random Start/Halt_req/Done traffic
      repeat (25) begin
         for (int a = 0; a < N; a++) begin
            int r, o;
            r = $urandom_range(99);
            o = r < 30 ? 0 : r < 55 ? 1 : r < 75 ? 2 : r < 90 ? 3 : r < 95 ? 7 : 4 + $urandom_range(2);
            rom[a] = {o[2:0], 6'($urandom)};
         end
         done_pct = $urandom_range(20, 70);
         cyc(1, 0, 0);
         repeat ($urandom_range(40, 150)) auto(3, 3);
         cyc(0, 1, 0);
         until_halt(200);
      end

      // count saturation, with mvi at the last address wrapping its immediate to address 0
      for (int a = 0; a < N; a++) rom[a] = 9'h081;
      rom[N-1] = 9'h040;
      done_pct = 100;
      cyc(1, 0, 0);
      repeat (1400) auto(0, 0);
      chk("sat_count", Instr_count, 255);
      cyc(0, 1, 0);
      until_halt(100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
